// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory and issue bus
interface fetch_unit_if #(
    parameter int WORD_SIZE = 16
);
    // Instruction memory read port
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ready;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Issue port towards the decision/execute stages
    logic [WORD_SIZE-1:0] instruction;
    logic [WORD_SIZE-1:0] peek_jump_address;
    logic [WORD_SIZE-1:0] program_counter_address;
    logic [WORD_SIZE-1:0] new_address;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 halted;

    // Fetch unit side
    modport master (
        output mem_req, mem_addr,
        input  mem_ready, mem_rdata,
        output instruction, peek_jump_address, program_counter_address,
        output instr_valid, halted,
        input  new_address, instr_ready
    );

    // Memory / downstream side
    modport slave (
        input  mem_req, mem_addr,
        output mem_ready, mem_rdata,
        input  instruction, peek_jump_address, program_counter_address,
        input  instr_valid, halted,
        output new_address, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with jump-target peek (optional HALT via FETCH_HALT_EN)
module fetch_unit #(
    parameter int                   WORD_SIZE     = 16,
    parameter logic [WORD_SIZE-1:0] RESET_ADDRESS = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam logic [WORD_SIZE-1:0] WORD_STEP  = WORD_SIZE'(2);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(1);
    localparam logic [7:0]           JUMP_LO    = 8'h14;
    localparam logic [7:0]           JUMP_HI    = 8'h24;

    typedef enum logic [1:0] {
        FETCH_INSTR = 2'd0,
        FETCH_PEEK  = 2'd1,
        ISSUE       = 2'd2
`ifdef FETCH_HALT_EN
        , HALTED    = 2'd3
`endif
    } state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] instruction_q;
    logic [WORD_SIZE-1:0] peek_q;
    logic [WORD_SIZE-1:0] pca_q;
    logic                 instr_valid_q;
    logic [7:0]           rdata_opcode;
    logic                 rdata_is_jump;
    logic [WORD_SIZE-1:0] peek_addr;

    // Opcode sits in the top byte of the word; jump opcodes need an operand word
    assign rdata_opcode  = bus.mem_rdata[WORD_SIZE-1 -: 8];
    assign rdata_is_jump = (rdata_opcode >= JUMP_LO) && (rdata_opcode <= JUMP_HI);
    assign peek_addr     = pc_q + WORD_STEP;

    // Request is decoded from the state so the address is stable until mem_ready;
    // reset gates it so nothing is requested in the reset cycle
    assign bus.mem_req  = ~reset & ((state_q == FETCH_INSTR) || (state_q == FETCH_PEEK));
    assign bus.mem_addr = (state_q == FETCH_PEEK) ? peek_addr : pc_q;

    assign bus.instruction             = instruction_q;
    assign bus.peek_jump_address       = peek_q;
    assign bus.program_counter_address = pca_q;
    assign bus.instr_valid             = instr_valid_q;

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic issue_is_halt;

    assign issue_is_halt = (instruction_q[WORD_SIZE-1 -: 8] == 8'hFF);
    assign bus.halted    = halted_q;
`else
    assign bus.halted    = 1'b0;
`endif

    // Fetch FSM: instruction read, optional operand read, then hold until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_INSTR;
            pc_q          <= RESET_ADDRESS;
            instruction_q <= '0;
            peek_q        <= '0;
            pca_q         <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_INSTR: begin
                    if (bus.mem_ready) begin
                        instruction_q <= bus.mem_rdata;
                        if (rdata_is_jump) begin
                            state_q <= FETCH_PEEK;
                        end else begin
                            peek_q        <= '0;
                            pca_q         <= pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= ISSUE;
                        end
                    end
                end
                FETCH_PEEK: begin
                    // The PC handed on points at the operand word, so a
                    // non-taken jump resolves past it
                    if (bus.mem_ready) begin
                        peek_q        <= bus.mem_rdata;
                        pca_q         <= peek_addr;
                        instr_valid_q <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (issue_is_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else begin
                            pc_q    <= bus.new_address & ALIGN_MASK;
                            state_q <= FETCH_INSTR;
                        end
`else
                        pc_q    <= bus.new_address & ALIGN_MASK;
                        state_q <= FETCH_INSTR;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALTED: begin
                    state_q <= HALTED;
                end
`endif
                default: begin
                    state_q <= FETCH_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with program-level reference model
module tb_fetch_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    fetch_unit_if #(.WORD_SIZE(16)) bus ();

    fetch_unit #(
        .WORD_SIZE     (16),
        .RESET_ADDRESS (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:32767];
    bit          mem_hold = 1'b0;
    bit          mon_on   = 1'b0;
    int          tests    = 0;
    int          fails    = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_jump(input logic [15:0] w);
        return (w[15:8] >= 8'h14) && (w[15:8] <= 8'h24);
    endfunction

    function automatic bit is_halt(input logic [15:0] w);
`ifdef FETCH_HALT_EN
        return w[15:8] == 8'hFF;
`else
        return (w[15:8] == 8'hFF) && 1'b0;
`endif
    endfunction

    task automatic put(input logic [15:0] addr, input logic [15:0] val);
        mem[addr[15:1]] = val;
    endtask

    // Memory: answers immediately unless held; junk data when not requested
    always @(negedge clk) begin
        #3;
        if (bus.mem_req === 1'b1) begin
            bus.mem_ready = !mem_hold;
            bus.mem_rdata = mem[bus.mem_addr[15:1]];
        end else begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 16'hDEAD;
        end
    end

    // Reference model: program-level view (current PC, words read so far)
    logic [15:0] m_pc      = 16'h0000;
    int          m_reads   = 0;
    bit          m_halted  = 1'b0;
    bit          m_cleared = 1'b1;

    always @(negedge clk) begin : monitor
        logic [15:0] w;
        logic [15:0] pa;
        int          need;
        bit          exp_req;
        bit          exp_valid;
        #4;
        if (mon_on) begin
            w         = mem[m_pc[15:1]];
            pa        = m_pc + 16'd2;
            need      = is_jump(w) ? 2 : 1;
            exp_req   = !reset && !m_halted && (m_reads < need);
            exp_valid = !m_halted && (m_reads == need);
            chk("mon_mem_req", 16'(bus.mem_req), 16'(exp_req));
            if (bus.mem_req === 1'b1)
                chk("mon_mem_addr", bus.mem_addr, m_pc + 16'(2 * m_reads));
            chk("mon_instr_valid", 16'(bus.instr_valid), 16'(exp_valid));
            chk("mon_halted", 16'(bus.halted), 16'(m_halted));
            if (exp_valid) begin
                chk("mon_instruction", bus.instruction, w);
                chk("mon_peek", bus.peek_jump_address, (need == 2) ? mem[pa[15:1]] : 16'h0000);
                chk("mon_pca", bus.program_counter_address, (need == 2) ? pa : m_pc);
            end else if (m_cleared) begin
                chk("mon_clr_instruction", bus.instruction, 16'h0000);
                chk("mon_clr_peek", bus.peek_jump_address, 16'h0000);
                chk("mon_clr_pca", bus.program_counter_address, 16'h0000);
            end
            // Advance to what the next edge must produce
            if (reset) begin
                m_pc      = 16'h0000;
                m_reads   = 0;
                m_halted  = 1'b0;
                m_cleared = 1'b1;
            end else if (!m_halted) begin
                if (exp_req && bus.mem_ready) begin
                    m_reads++;
                    m_cleared = 1'b0;
                end else if (exp_valid && bus.instr_ready) begin
                    if (is_halt(w)) begin
                        m_halted = 1'b1;
                    end else begin
                        m_pc    = bus.new_address & 16'hFFFE;
                        m_reads = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [15:0] addr);
        chk({name, "_req"}, 16'(bus.mem_req), 16'h0001);
        chk({name, "_addr"}, bus.mem_addr, addr);
        chk({name, "_valid"}, 16'(bus.instr_valid), 16'h0000);
    endtask

    task automatic chk_issue(input string name, input logic [15:0] ins,
                             input logic [15:0] peek, input logic [15:0] pca);
        chk({name, "_valid"}, 16'(bus.instr_valid), 16'h0001);
        chk({name, "_req"}, 16'(bus.mem_req), 16'h0000);
        chk({name, "_instr"}, bus.instruction, ins);
        chk({name, "_peek"}, bus.peek_jump_address, peek);
        chk({name, "_pca"}, bus.program_counter_address, pca);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_valid"}, 16'(bus.instr_valid), 16'h0000);
        chk({name, "_instr"}, bus.instruction, 16'h0000);
        chk({name, "_peek"}, bus.peek_jump_address, 16'h0000);
        chk({name, "_pca"}, bus.program_counter_address, 16'h0000);
        chk({name, "_halted"}, 16'(bus.halted), 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        put(16'h0000, 16'h0100);
        put(16'h0002, 16'h3000);
        put(16'h0010, 16'h1400);
        put(16'h0012, 16'h0040);
        put(16'h0022, 16'h1300);
        put(16'h0040, 16'h2400);
        put(16'h0042, 16'h1234);
        put(16'h0050, 16'h2500);
        put(16'h0060, 16'h1400);
        put(16'h0062, 16'h0099);
        put(16'h0070, 16'hFF00);
        put(16'h0080, 16'h0200);
        put(16'hFFFE, 16'h1500);

        bus.instr_ready = 1'b0;
        bus.new_address = 16'h0000;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 16'h0000;

        // Reset state, then first fetch at RESET_ADDRESS
        cyc();
        chk_reset_vals("rst");
        chk("rst_req", 16'(bus.mem_req), 16'h0000);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        mon_on          = 1'b1;
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        bus.new_address = 16'h0002;
        #1;
        chk_fetch("t1_fetch", 16'h0000);
        cyc(); chk_issue("t1_issue", 16'h0100, 16'h0000, 16'h0000);
        cyc(); chk_fetch("t1_next", 16'h0002);
        bus.new_address = 16'h0011;
        cyc(); chk_issue("t1b_issue", 16'h3000, 16'h0000, 16'h0002);

        // Jump with operand word; odd new_address forced even
        cyc(); chk_fetch("t2_fetch", 16'h0010);
        bus.new_address = 16'h0040;
        cyc(); chk_fetch("t2_peek", 16'h0012);
        cyc(); chk_issue("t2_issue", 16'h1400, 16'h0040, 16'h0012);

        // Memory wait during operand read
        cyc(); chk_fetch("t3_fetch", 16'h0040);
        cyc(); mem_hold = 1'b1; chk_fetch("t3_wait0", 16'h0042);
        cyc(); chk_fetch("t3_wait1", 16'h0042);
        cyc(); chk_fetch("t3_wait2", 16'h0042);
        cyc(); mem_hold = 1'b0; bus.instr_ready = 1'b0; chk_fetch("t3_done", 16'h0042);

        // Downstream back-pressure in ISSUE
        for (int i = 0; i < 4; i++) begin
            cyc(); chk_issue("t4_hold", 16'h2400, 16'h1234, 16'h0042);
        end
        cyc();
        bus.instr_ready = 1'b1;
        bus.new_address = 16'h0023;
        chk_issue("t4_accept", 16'h2400, 16'h1234, 16'h0042);
        cyc(); chk_fetch("t4_next", 16'h0022);
        bus.new_address = 16'hFFFE;
        cyc(); chk_issue("t4b_issue", 16'h1300, 16'h0000, 16'h0022);

        // Jump at top of memory wraps the operand read to 0
        cyc(); chk_fetch("t5_fetch", 16'hFFFE);
        cyc(); chk_fetch("t5_peek", 16'h0000);
        cyc(); chk_issue("t5_issue", 16'h1500, 16'h0100, 16'h0000);
        bus.new_address = 16'h0050;
        cyc(); chk_fetch("t5b_fetch", 16'h0050);
        bus.new_address = 16'h0060;
        cyc(); chk_issue("t5b_issue", 16'h2500, 16'h0000, 16'h0050);

        // Reset while waiting on mem_ready
        cyc(); chk_fetch("t5c_fetch", 16'h0060);
        cyc(); mem_hold = 1'b1; chk_fetch("t5c_peek", 16'h0062);
        cyc();
        chk_fetch("t5c_wait", 16'h0062);
        reset    = 1'b1;
        mem_hold = 1'b0;
        #1;
        chk("t5c_rst_req", 16'(bus.mem_req), 16'h0000);
        cyc();
        chk_reset_vals("t5c_after");
        reset           = 1'b0;
        bus.new_address = 16'h0070;
        #1;
        chk_fetch("t5c_refetch", 16'h0000);
        cyc(); chk_issue("t5c_issue", 16'h0100, 16'h0000, 16'h0000);

        // Opcode 8'hFF
        cyc(); chk_fetch("t6_fetch", 16'h0070);
        bus.new_address = 16'h0080;
        cyc(); chk_issue("t6_issue", 16'hFF00, 16'h0000, 16'h0070);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t6_halted", 16'(bus.halted), 16'h0001);
            chk("t6_req", 16'(bus.mem_req), 16'h0000);
            chk("t6_valid", 16'(bus.instr_valid), 16'h0000);
        end
`else
        cyc();
        chk_fetch("t6_next", 16'h0080);
        chk("t6_halted", 16'(bus.halted), 16'h0000);
        cyc(); chk_issue("t6b_issue", 16'h0200, 16'h0000, 16'h0080);
        for (int i = 0; i < 3; i++) cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the jump decision unit.
- Holds the program counter and reads the instruction word from instruction memory over a req/ready handshake.
- For jump opcodes (8'h14..8'h24), also reads the following word as the jump target.
- Presents instruction, target and PC to the decision/execute stages; on handoff, loads the next PC from the decision unit's new_address.

Parameters:
- WORD_SIZE, 16, data/address width; byte-addressed, one word = 2 bytes.
- RESET_ADDRESS, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  instruction memory read request
- mem_addr  out  WORD_SIZE  read address; stable while mem_req=1
- mem_ready  in  1  read completes this cycle; mem_rdata valid
- mem_rdata  in  WORD_SIZE  read data
- instruction  out  WORD_SIZE  fetched instruction word (opcode in [15:8])
- peek_jump_address  out  WORD_SIZE  jump target word; 0 for non-jumps
- program_counter_address  out  WORD_SIZE  PC handed to decision unit
- new_address  in  WORD_SIZE  next PC from decision unit
- instr_valid  out  1  instruction outputs valid
- instr_ready  in  1  downstream accepts the instruction
- halted  out  1  fetch halted (see Optional Feature)

Behaviour:
- Single clock domain. Reset is synchronous and active-high, checked at every posedge clk and overriding all else.
- Reset values:
  - pc=RESET_ADDRESS, state=FETCH_INSTR.
  - mem_req=0 in the reset cycle; mem_addr=RESET_ADDRESS.
  - instruction=0, peek_jump_address=0, program_counter_address=0, instr_valid=0, halted=0.
- Reset mid-operation: any outstanding request is abandoned. A mem_ready in the reset cycle is ignored.
- States:
  - FETCH_INSTR: mem_req=1, mem_addr=pc.
    - On mem_ready: instruction<=mem_rdata.
    - If mem_rdata[15:8] is in 8'h14..8'h24 (jump): go to FETCH_PEEK.
    - Otherwise: peek_jump_address<=0, program_counter_address<=pc, go to ISSUE.
  - FETCH_PEEK: mem_req=1, mem_addr=pc+2.
    - On mem_ready: peek_jump_address<=mem_rdata, program_counter_address<=pc+2, go to ISSUE.
    - Non-taken jumps therefore resolve to pc+4, skipping the operand word.
  - ISSUE: mem_req=0, instr_valid=1.
    - All instruction outputs are held stable until accepted.
    - On instr_ready: pc<={new_address[WORD_SIZE-1:1],1'b0}, instr_valid<=0, go to FETCH_INSTR.
    - new_address is sampled in the accept cycle.
    - instr_ready while instr_valid=0 is ignored.
- Handshakes:
  - mem_req stays high and mem_addr stays constant until mem_ready; no request is ever withdrawn except by reset.
  - mem_ready while mem_req=0 is ignored.
- Latency, zero memory wait and immediate instr_ready:
  - Non-jump: 2 cycles per instruction (FETCH_INSTR, ISSUE).
  - Jump: 3 cycles per instruction.
- Arithmetic: all PC arithmetic is modulo 2^WORD_SIZE. A jump at pc=16'hFFFE peeks address 16'h0000.
- Alignment: PC bit 0 is always 0. An odd new_address is forced even.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - Opcode 8'hFF is HALT.
  - On acceptance of a HALT (instr_valid & instr_ready), go to HALTED. pc is unchanged and new_address is ignored.
  - HALTED: mem_req=0, instr_valid=0, halted=1. Only reset exits.
- Undefined:
  - 8'hFF is an ordinary non-jump instruction.
  - halted is tied 0; the HALTED state does not exist.

Test Plan:
1. Reset, mem_ready=1 always, mem[0]=16'h0100, instr_ready=1, new_address=16'h0002 -> cycle 1: mem_req=1, mem_addr=0. Cycle 2: instr_valid=1, instruction=16'h0100, program_counter_address=0, peek=0. Next mem_addr=16'h0002.
2. pc=16'h0010, mem[10]=16'h1400, mem[12]=16'h0040 -> two requests (16'h0010, then 16'h0012). Issue shows program_counter_address=16'h0012, peek_jump_address=16'h0040. With new_address=16'h0040, next fetch address is 16'h0040.
3. mem_ready low 3 cycles during FETCH_PEEK -> mem_req=1 and mem_addr=pc+2 held 3 cycles; instr_valid stays 0 until the cycle after mem_ready.
4. instr_ready low 4 cycles in ISSUE -> instr_valid=1 and outputs unchanged for 4 cycles; mem_req=0 throughout. With new_address=16'h0023, next pc=16'h0022.
5. Jump at pc=16'hFFFE -> peek mem_addr=16'h0000. Reset asserted while waiting on mem_ready -> next cycle pc=RESET_ADDRESS, instr_valid=0, state FETCH_INSTR.
6. With FETCH_HALT_EN: fetch 16'hFF00 and accept -> halted=1, mem_req=0 forever, instr_valid=0. Without FETCH_HALT_EN: the same word issues normally and fetch continues at new_address.
